// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: receiver FSM states and 16x oversampling constants.
// The transmitter uses the same sample-point constants.
package uart_rx_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int SCNT_W     = $clog2(OVERSAMPLE);

    localparam logic [SCNT_W-1:0] MID_SAMPLE  = SCNT_W'(7);
    localparam logic [SCNT_W-1:0] LAST_SAMPLE = SCNT_W'(15);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } rx_state_e;

endpackage

// File: rtl/uart_tick_gen.sv
// Oversample tick generator: one-clk enable every (ubrr+1) cycles.
// Meant to be shared with a transmitter instead of dividing down a clock.
module uart_tick_gen #(
    parameter int CNT_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] ubrr,
    output logic             tick
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // A ubrr lowered below the current count lets cnt wrap through all-ones.
    always_comb begin
        tick  = (cnt_q == ubrr);
        cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling, valid/ack byte handshake,
// framing-error pulse, sticky overrun and line-break recovery.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [11:0]          ubrr,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ack,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int BIDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [BIDX_W-1:0] LAST_BIT = BIDX_W'(DATA_BITS - 1);

    logic                   tick;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   rxd_s;

    rx_state_e              state_q, state_d;
    logic [SCNT_W-1:0]      scnt_q, scnt_d;
    logic [BIDX_W-1:0]      bidx_q, bidx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;

    logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   overrun_q, overrun_d;
    logic                   frame_err_q, frame_err_d;

    logic                   stop_ok;
    logic                   stop_bad;

    uart_tick_gen #(
        .CNT_W (12)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .ubrr (ubrr),
        .tick (tick)
    );

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], rxd};
    end

    assign rxd_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d  = state_q;
        scnt_d   = scnt_q;
        bidx_d   = bidx_q;
        shift_d  = shift_q;
        stop_ok  = 1'b0;
        stop_bad = 1'b0;
        if (tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (!rxd_s) begin
                        state_d = ST_START;
                        scnt_d  = '0;
                    end
                end
                // Start bit must still be low at its midpoint, otherwise it was a glitch.
                ST_START: begin
                    if (scnt_q == MID_SAMPLE) begin
                        if (!rxd_s) begin
                            state_d = ST_DATA;
                            scnt_d  = '0;
                            bidx_d  = '0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        scnt_d = scnt_q + SCNT_W'(1);
                    end
                end
                ST_DATA: begin
                    scnt_d = scnt_q + SCNT_W'(1);
                    if (scnt_q == LAST_SAMPLE) begin
                        shift_d = {rxd_s, shift_q[DATA_BITS-1:1]};
                        bidx_d  = bidx_q + BIDX_W'(1);
                        if (bidx_q == LAST_BIT) begin
                            state_d = ST_STOP;
                            scnt_d  = '0;
                        end
                    end
                end
                ST_STOP: begin
                    scnt_d = scnt_q + SCNT_W'(1);
                    if (scnt_q == LAST_SAMPLE) begin
                        if (rxd_s) begin
                            stop_ok = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            stop_bad = 1'b1;
                            state_d  = ST_BREAK;
                        end
                    end
                end
                // Hold off until the line idles so a stuck-low rxd cannot restart frames.
                ST_BREAK: begin
                    if (rxd_s) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        overrun_d   = overrun_q;
        frame_err_d = stop_bad;
        if (stop_ok) begin
            if (!rx_valid_q || rx_ack) begin
                rx_data_d  = shift_q;
                rx_valid_d = 1'b1;
                if (rx_ack) begin
                    overrun_d = 1'b0;
                end
            end else begin
                overrun_d = 1'b1;
            end
        end else if (rx_ack && rx_valid_q) begin
            rx_valid_d = 1'b0;
            overrun_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q      <= '1;
            state_q     <= ST_IDLE;
            scnt_q      <= '0;
            bidx_q      <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            state_q     <= state_d;
            scnt_q      <= scnt_d;
            bidx_q      <= bidx_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: table of single frames plus hand-written
// sequences for back-to-back, glitch, line break, overrun and mid-frame reset.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int SYNC = 2;

    logic        clk;
    logic        rst;
    logic [11:0] ubrr;
    logic        rxd;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ack;
    logic        frame_err;
    logic        overrun;
    logic        busy;

    logic        ack_man;
    logic        ack_auto;
    logic        auto_en;

    int n_tests = 0;
    int n_fail  = 0;

    int ferr_n     = 0;
    int ferr_long  = 0;
    int busy_falls = 0;
    int log_n      = 0;
    logic [7:0] rx_log [16];
    logic ferr_prev  = 1'b0;
    logic busy_prev  = 1'b0;
    logic valid_prev = 1'b0;

    typedef struct {
        logic [11:0] ubrr;
        logic [7:0]  data;
        logic        stop;
        logic [7:0]  exp_data;
        logic        exp_valid;
        int          exp_ferr;
    } vec_t;

    vec_t vecs [6];

    assign rx_ack = ack_man | ack_auto;

    uart_rx #(
        .DATA_BITS   (8),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ubrr      (ubrr),
        .rxd       (rxd),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ack    (rx_ack),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        ferr_prev  <= frame_err;
        busy_prev  <= busy;
        valid_prev <= rx_valid;
        if (frame_err) ferr_n <= ferr_n + 1;
        if (frame_err && ferr_prev) ferr_long <= ferr_long + 1;
        if (!busy && busy_prev) busy_falls <= busy_falls + 1;
        if (rx_valid && !valid_prev) begin
            rx_log[log_n % 16] <= rx_data;
            log_n <= log_n + 1;
        end
    end

    initial begin
        ack_auto = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            ack_auto = auto_en && rx_valid && !ack_auto;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) step();
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_rng(input string name, input int act, input int lo, input int hi);
        n_tests++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    function automatic int bit_time();
        return 16 * (int'(ubrr) + 1);
    endfunction

    task automatic pulse_rst();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
    endtask

    // Lowering ubrr while idle would let the divider wrap through 4095, so reset instead.
    task automatic set_ubrr(input logic [11:0] v);
        if (v < ubrr) begin
            ubrr = v;
            pulse_rst();
        end else begin
            ubrr = v;
        end
        idle(bit_time());
    endtask

    // lat = cycles from stop-bit start until rx_valid is first seen high (0 if never).
    task automatic send_frame(input logic [7:0] d, input logic stop, output int lat);
        int bt;
        bt  = bit_time();
        lat = 0;
        rxd = 1'b0;
        repeat (bt) step();
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            repeat (bt) step();
        end
        rxd = stop;
        for (int c = 1; c <= bt; c++) begin
            step();
            if (rx_valid && lat == 0) begin
                lat     = c;
                ack_man = 1'b0;
            end
        end
        rxd = 1'b1;
    endtask

    task automatic ack_once();
        ack_man = 1'b1;
        step();
        ack_man = 1'b0;
    endtask

    initial begin
        int lat, lo, hi, f0, l0, b0, fl0, bt;

        vecs[0] = '{12'd0, 8'h00, 1'b1, 8'h00, 1'b1, 0};
        vecs[1] = '{12'd0, 8'hFF, 1'b1, 8'hFF, 1'b1, 0};
        vecs[2] = '{12'd1, 8'hA5, 1'b1, 8'hA5, 1'b1, 0};
        vecs[3] = '{12'd1, 8'h3C, 1'b0, 8'hA5, 1'b0, 1};
        vecs[4] = '{12'd2, 8'h5A, 1'b1, 8'h5A, 1'b1, 0};
        vecs[5] = '{12'd3, 8'h81, 1'b1, 8'h81, 1'b1, 0};

        rst     = 1'b1;
        rxd     = 1'b1;
        ubrr    = 12'd0;
        ack_man = 1'b0;
        auto_en = 1'b0;
        repeat (3) step();
        check("reset rx_data", rx_data, 8'h00);
        check("reset rx_valid", rx_valid, 1'b0);
        check("reset frame_err", frame_err, 1'b0);
        check("reset overrun", overrun, 1'b0);
        check("reset busy", busy, 1'b0);
        rst = 1'b0;
        idle(5);

        for (int v = 0; v < 6; v++) begin
            set_ubrr(vecs[v].ubrr);
            bt = bit_time();
            f0 = ferr_n;
            send_frame(vecs[v].data, vecs[v].stop, lat);
            idle(bt / 2);
            check($sformatf("vec%0d rx_data", v), rx_data, vecs[v].exp_data);
            check($sformatf("vec%0d rx_valid", v), rx_valid, vecs[v].exp_valid);
            check($sformatf("vec%0d frame_err count", v), ferr_n - f0, vecs[v].exp_ferr);
            check($sformatf("vec%0d overrun", v), overrun, 1'b0);
            check($sformatf("vec%0d busy idle", v), busy, 1'b0);
            if (vecs[v].exp_valid) begin
                lo = bt / 2 + SYNC + 1;
                hi = lo + int'(ubrr);
                check_rng($sformatf("vec%0d valid latency", v), lat, lo, hi);
                ack_once();
                check($sformatf("vec%0d rx_valid after ack", v), rx_valid, 1'b0);
            end
        end

        // Back-to-back frames at ubrr=0 with the host acking each byte.
        set_ubrr(12'd0);
        auto_en = 1'b1;
        l0 = log_n;
        b0 = busy_falls;
        send_frame(8'h00, 1'b1, lat);
        send_frame(8'hFF, 1'b1, lat);
        idle(32);
        check("b2b byte count", log_n - l0, 2);
        check("b2b byte0", rx_log[l0 % 16], 8'h00);
        check("b2b byte1", rx_log[(l0 + 1) % 16], 8'hFF);
        check("b2b overrun", overrun, 1'b0);
        check("b2b busy falls", busy_falls - b0, 2);
        check("b2b rx_valid", rx_valid, 1'b0);
        auto_en = 1'b0;
        idle(4);

        // Short low glitch at ubrr=3 is rejected at the start-bit midpoint.
        set_ubrr(12'd3);
        f0 = ferr_n;
        l0 = log_n;
        rxd = 1'b0;
        repeat (20) step();
        check("glitch busy during low", busy, 1'b1);
        idle(100);
        check("glitch busy after", busy, 1'b0);
        check("glitch rx_valid", rx_valid, 1'b0);
        check("glitch frame_err count", ferr_n - f0, 0);
        check("glitch no byte", log_n - l0, 0);

        // Framing error followed by a stuck-low line, then a good frame.
        set_ubrr(12'd1);
        f0  = ferr_n;
        fl0 = ferr_long;
        send_frame(8'h3C, 1'b0, lat);
        rxd = 1'b0;
        repeat (100) step();
        check("break busy while low", busy, 1'b1);
        check("break frame_err count", ferr_n - f0, 1);
        check("break frame_err width", ferr_long - fl0, 0);
        check("break rx_valid", rx_valid, 1'b0);
        idle(8);
        check("break busy released", busy, 1'b0);
        send_frame(8'h5A, 1'b1, lat);
        idle(16);
        check("after break rx_data", rx_data, 8'h5A);
        check("after break rx_valid", rx_valid, 1'b1);
        ack_once();

        // Overrun: two frames without ack, then ack, then ack held into a delivery.
        idle(32);
        send_frame(8'h11, 1'b1, lat);
        idle(32);
        send_frame(8'h22, 1'b1, lat);
        idle(16);
        check("overrun rx_data", rx_data, 8'h11);
        check("overrun rx_valid", rx_valid, 1'b1);
        check("overrun flag", overrun, 1'b1);
        ack_once();
        check("overrun ack rx_valid", rx_valid, 1'b0);
        check("overrun ack flag", overrun, 1'b0);
        idle(32);
        ack_man = 1'b1;
        send_frame(8'h33, 1'b1, lat);
        ack_man = 1'b0;
        idle(16);
        check("ack-on-delivery rx_data", rx_data, 8'h33);
        check("ack-on-delivery rx_valid", rx_valid, 1'b1);
        check("ack-on-delivery overrun", overrun, 1'b0);
        check_rng("ack-on-delivery latency", lat, 16 + SYNC + 1, 16 + SYNC + 2);

        // Reset in the middle of data bit 4 with 0x33 still pending.
        idle(32);
        bt  = bit_time();
        rxd = 1'b0;
        repeat (bt) step();
        for (int i = 0; i < 4; i++) begin
            rxd = 1'b1;
            repeat (bt) step();
        end
        rxd = 1'b0;
        repeat (bt / 2) step();
        check("pre-reset busy", busy, 1'b1);
        rst = 1'b1;
        step();
        check("mid-rst rx_data", rx_data, 8'h00);
        check("mid-rst rx_valid", rx_valid, 1'b0);
        check("mid-rst frame_err", frame_err, 1'b0);
        check("mid-rst overrun", overrun, 1'b0);
        check("mid-rst busy", busy, 1'b0);
        rxd = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        f0 = ferr_n;
        idle(2 * bt);
        check("post-rst busy", busy, 1'b0);
        send_frame(8'h81, 1'b1, lat);
        idle(16);
        check("post-rst rx_data", rx_data, 8'h81);
        check("post-rst rx_valid", rx_valid, 1'b1);
        check("post-rst frame_err count", ferr_n - f0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
